// File: rtl/itlb_cache.sv
// itlb_cache: instruction micro-TLB in front of the main TLB.
// Recently used TLB pairs are cached so mapped fetches translate in the same
// cycle. A mapped miss stalls fetch and runs a req/ack lookup to the main TLB,
// which either fills an entry or leaves the FSM in FAULT to report a refill.
module itlb_cache #(
  parameter int ENTRY_NUM = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        inst_en,
  input  logic [31:0] inst_vaddr,
  input  logic        stallF,
  input  logic [7:0]  asid,
  input  logic        tlb_flush,
  output logic [19:0] inst_pfn,
  output logic        no_cache_i,
  output logic        inst_tlb_refill,
  output logic        inst_tlb_invalid,
  output logic        itlb_stall,
  output logic        lk_req,
  output logic [18:0] lk_vpn2,
  output logic [7:0]  lk_asid,
  input  logic        lk_ack,
  input  logic        lk_found,
  input  logic        lk_g,
  input  logic [31:0] lk_lo0,
  input  logic [31:0] lk_lo1
);

  localparam int IDX_W = $clog2(ENTRY_NUM);

  typedef enum logic [1:0] {S_IDLE, S_REQ, S_FAULT} state_t;

  // Entry storage: valid is control state, the rest is payload.
  logic [ENTRY_NUM-1:0] r_valid;
  logic [18:0]          r_vpn2 [ENTRY_NUM];
  logic [7:0]           r_asid [ENTRY_NUM];
  logic                 r_g    [ENTRY_NUM];
  logic [19:0]          r_pfn0 [ENTRY_NUM];
  logic [19:0]          r_pfn1 [ENTRY_NUM];
  logic [2:0]           r_c0   [ENTRY_NUM];
  logic [2:0]           r_c1   [ENTRY_NUM];
  logic                 r_v0   [ENTRY_NUM];
  logic                 r_v1   [ENTRY_NUM];

  state_t               r_state;
  logic [IDX_W-1:0]     r_rr;
  logic                 r_drop;
  logic                 r_lk_req;
  logic [18:0]          r_req_vpn2;
  logic [7:0]           r_req_asid;
  logic [7:0]           r_asid_q;

  logic [18:0]          w_vpn2;
  logic                 w_odd;
  logic                 w_en;
  logic                 w_mapped;
  logic [ENTRY_NUM-1:0] w_hit_vec;
  logic                 w_hit;
  logic [19:0]          w_pfn_sel;
  logic [2:0]           w_c_sel;
  logic                 w_v_sel;
  logic                 w_miss;
  logic                 w_fault_match;
  logic                 w_flush;
  logic                 w_fill;
  logic [IDX_W-1:0]     w_victim;
  logic                 w_unused;

  assign w_vpn2   = inst_vaddr[31:13];
  assign w_odd    = inst_vaddr[12];
  assign w_en     = inst_en & rst;
  assign w_mapped = (inst_vaddr[31:30] != 2'b10);
  assign w_flush  = tlb_flush | (asid != r_asid_q);

  // A fill happens only on a live, non-discarded, successful lookup ack.
  assign w_fill = (r_state == S_REQ) & r_lk_req & lk_ack & ~r_drop & lk_found;

  // Fields of EntryLo that the micro-TLB never stores (D bit, G slot, upper bits).
  assign w_unused = ^{inst_vaddr[11:0], lk_lo0[31:26], lk_lo0[2], lk_lo0[0],
                      lk_lo1[31:26], lk_lo1[2], lk_lo1[0]};

  // Associative match and even/odd half selection of the hitting entry.
  always_comb begin
    w_hit     = 1'b0;
    w_pfn_sel = '0;
    w_c_sel   = '0;
    w_v_sel   = 1'b0;
    w_hit_vec = '0;
    for (int i = 0; i < ENTRY_NUM; i++) begin
      w_hit_vec[i] = r_valid[i] && (r_vpn2[i] == w_vpn2) &&
                     (r_g[i] || (r_asid[i] == asid));
      if (w_hit_vec[i]) begin
        w_hit     = 1'b1;
        w_pfn_sel = w_odd ? r_pfn1[i] : r_pfn0[i];
        w_c_sel   = w_odd ? r_c1[i]   : r_c0[i];
        w_v_sel   = w_odd ? r_v1[i]   : r_v0[i];
      end
    end
  end

  // Victim: lowest-index free entry, falling back to the round-robin pointer.
  always_comb begin
    w_victim = r_rr;
    for (int i = ENTRY_NUM - 1; i >= 0; i--) begin
      if (!r_valid[i]) w_victim = IDX_W'(i);
    end
  end

  assign w_miss        = w_en & w_mapped & ~w_hit;
  // In FAULT the faulting page reports a refill instead of stalling again.
  assign w_fault_match = (r_state == S_FAULT) & (w_vpn2 == r_req_vpn2);

  assign inst_tlb_refill  = w_miss & w_fault_match;
  assign itlb_stall       = w_miss & ~w_fault_match;
  assign inst_tlb_invalid = w_en & w_mapped & w_hit & ~w_v_sel;
  assign inst_pfn         = w_mapped ? w_pfn_sel : {3'b000, inst_vaddr[28:12]};
  assign no_cache_i       = w_mapped ? (w_c_sel == 3'b010)
                                     : (inst_vaddr[31:29] == 3'b101);

  assign lk_req  = r_lk_req;
  assign lk_vpn2 = r_req_vpn2;
  assign lk_asid = r_req_asid;

  // Control: valid bits, lookup FSM, request registers, ASID tracking.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_valid    <= '0;
      r_rr       <= '0;
      r_state    <= S_IDLE;
      r_drop     <= 1'b0;
      r_lk_req   <= 1'b0;
      r_req_vpn2 <= '0;
      r_req_asid <= '0;
      r_asid_q   <= '0;
    end else begin
      r_asid_q <= asid;
      // Flush wins even over an entry being filled in the same cycle.
      if (w_flush) r_valid <= '0;
      else if (w_fill) r_valid[w_victim] <= 1'b1;

      case (r_state)
        S_IDLE: begin
          if (w_miss) begin
            r_req_vpn2 <= w_vpn2;
            r_req_asid <= asid;
            r_lk_req   <= 1'b1;
            r_drop     <= 1'b0;
            r_state    <= S_REQ;
          end
        end
        S_REQ: begin
          if (!r_lk_req) begin
            // Reissue after a discarded ack, picking up the current ASID.
            r_lk_req   <= 1'b1;
            r_req_asid <= asid;
          end else if (lk_ack) begin
            r_lk_req <= 1'b0;
            if (r_drop) begin
              r_drop <= 1'b0;
            end else if (lk_found) begin
              r_rr    <= r_rr + IDX_W'(1);
              r_state <= S_IDLE;
            end else begin
              r_state <= S_FAULT;
            end
          end else if (w_flush) begin
            // The in-flight answer may predate the TLB write; discard it.
            r_drop <= 1'b1;
          end
        end
        S_FAULT: begin
          if (w_flush || (w_vpn2 != r_req_vpn2) || !stallF) r_state <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  // Payload write of the victim entry on a successful fill.
  always_ff @(posedge clk) begin
    if (w_fill) begin
      r_vpn2[w_victim] <= r_req_vpn2;
      r_asid[w_victim] <= r_req_asid;
      r_g[w_victim]    <= lk_g;
      r_pfn0[w_victim] <= lk_lo0[25:6];
      r_c0[w_victim]   <= lk_lo0[5:3];
      r_v0[w_victim]   <= lk_lo0[1];
      r_pfn1[w_victim] <= lk_lo1[25:6];
      r_c1[w_victim]   <= lk_lo1[5:3];
      r_v1[w_victim]   <= lk_lo1[1];
    end
  end

endmodule

// File: tb/tb_itlb_cache.sv
// tb_itlb_cache: directed bench for the instruction micro-TLB.
module tb_itlb_cache;

  localparam int NE = 4;

  logic        clk;
  logic        rst;
  logic        inst_en;
  logic [31:0] inst_vaddr;
  logic        stallF;
  logic [7:0]  asid;
  logic        tlb_flush;
  logic [19:0] inst_pfn;
  logic        no_cache_i;
  logic        inst_tlb_refill;
  logic        inst_tlb_invalid;
  logic        itlb_stall;
  logic        lk_req;
  logic [18:0] lk_vpn2;
  logic [7:0]  lk_asid;
  logic        lk_ack;
  logic        lk_found;
  logic        lk_g;
  logic [31:0] lk_lo0;
  logic [31:0] lk_lo1;

  int checks;
  int failures;

  // Observation vector: {stall, refill, invalid, nc, pfn[19:0], req, asid[7:0], vpn2[18:0]}
  localparam logic [51:0] M_EXC = {3'b111, 49'b0};
  localparam logic [51:0] M_NC  = {3'b000, 1'b1, 48'b0};
  localparam logic [51:0] M_PFN = {4'b0, 20'hFFFFF, 28'b0};
  localparam logic [51:0] M_REQ = {24'b0, 1'b1, 27'b0};
  localparam logic [51:0] M_LK  = {25'b0, 27'h7FFFFFF};

  typedef struct {
    string       tag;
    logic [51:0] val;
    logic [51:0] mask;
  } sb_t;

  sb_t sb[$];

  itlb_cache #(.ENTRY_NUM(NE)) dut (
    .clk(clk), .rst(rst), .inst_en(inst_en), .inst_vaddr(inst_vaddr),
    .stallF(stallF), .asid(asid), .tlb_flush(tlb_flush),
    .inst_pfn(inst_pfn), .no_cache_i(no_cache_i),
    .inst_tlb_refill(inst_tlb_refill), .inst_tlb_invalid(inst_tlb_invalid),
    .itlb_stall(itlb_stall), .lk_req(lk_req), .lk_vpn2(lk_vpn2),
    .lk_asid(lk_asid), .lk_ack(lk_ack), .lk_found(lk_found), .lk_g(lk_g),
    .lk_lo0(lk_lo0), .lk_lo1(lk_lo1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  function automatic logic [51:0] mk(input logic s, input logic rf, input logic iv,
                                     input logic nc, input logic [19:0] pfn,
                                     input logic rq, input logic [7:0] as,
                                     input logic [18:0] vp);
    return {s, rf, iv, nc, pfn, rq, as, vp};
  endfunction

  function automatic logic [31:0] mk_lo(input logic [19:0] pfn, input logic [2:0] c,
                                        input logic v);
    return {6'b0, pfn, c, 1'b0, v, 1'b0};
  endfunction

  task automatic check_front();
    sb_t e;
    logic [51:0] obs;
    obs = {itlb_stall, inst_tlb_refill, inst_tlb_invalid, no_cache_i, inst_pfn,
           lk_req, lk_asid, lk_vpn2};
    e = sb.pop_front();
    checks++;
    assert ((obs & e.mask) === (e.val & e.mask)) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", e.tag, obs & e.mask, e.val & e.mask);
    end
  endtask

  task automatic step(input string tag, input logic [51:0] val, input logic [51:0] mask);
    sb_t e;
    e.tag  = tag;
    e.val  = val;
    e.mask = mask;
    sb.push_back(e);
    #2;
    check_front();
  endtask

  task automatic hit(input string tag, input logic [31:0] va, input logic [19:0] pfn,
                     input logic nc, input logic inv);
    @(negedge clk);
    inst_en    = 1'b1;
    inst_vaddr = va;
    step(tag, mk(1'b0, 1'b0, inv, nc, pfn, 1'b0, 8'h0, 19'h0), M_EXC | M_NC | M_PFN);
  endtask

  // Miss, one-cycle ack with a hit from the main TLB, then the translated hit.
  task automatic fill(input string tag, input logic [31:0] va, input logic g,
                      input logic [31:0] lo0, input logic [31:0] lo1);
    logic [31:0] lo_sel;
    lo_sel = va[12] ? lo1 : lo0;
    @(negedge clk);
    lk_ack     = 1'b0;
    inst_en    = 1'b1;
    inst_vaddr = va;
    step({tag, "_miss"}, mk(1'b1, 1'b0, 1'b0, 1'b0, 20'h0, 1'b0, 8'h0, 19'h0),
         M_EXC | M_REQ);
    @(negedge clk);
    lk_ack   = 1'b1;
    lk_found = 1'b1;
    lk_g     = g;
    lk_lo0   = lo0;
    lk_lo1   = lo1;
    step({tag, "_req"}, mk(1'b1, 1'b0, 1'b0, 1'b0, 20'h0, 1'b1, asid, va[31:13]),
         M_EXC | M_REQ | M_LK);
    @(negedge clk);
    lk_ack   = 1'b0;
    lk_found = 1'b0;
    step({tag, "_hit"}, mk(1'b0, 1'b0, ~lo_sel[1], (lo_sel[5:3] == 3'b010),
                           lo_sel[25:6], 1'b0, 8'h0, 19'h0),
         M_EXC | M_NC | M_PFN | M_REQ);
  endtask

  initial begin
    checks     = 0;
    failures   = 0;
    rst        = 1'b0;
    inst_en    = 1'b0;
    inst_vaddr = 32'h0;
    stallF     = 1'b0;
    asid       = 8'd5;
    tlb_flush  = 1'b0;
    lk_ack     = 1'b0;
    lk_found   = 1'b0;
    lk_g       = 1'b0;
    lk_lo0     = 32'h0;
    lk_lo1     = 32'h0;

    // Reset state, with a mapped fetch that must not stall or fault.
    repeat (2) @(negedge clk);
    inst_en    = 1'b1;
    inst_vaddr = 32'h0040_1000;
    step("rst_state", mk(1'b0, 1'b0, 1'b0, 1'b0, 20'h0, 1'b0, 8'h0, 19'h0),
         M_EXC | M_REQ | M_LK);
    @(negedge clk);
    rst     = 1'b1;
    inst_en = 1'b0;
    @(negedge clk);

    // Unmapped segments.
    hit("kseg1", 32'hBFC0_0000, 20'h1FC00, 1'b1, 1'b0);
    hit("kseg0", 32'h8000_1000, 20'h00001, 1'b0, 1'b0);

    // Mapped miss, fill from Lo1, then hits on both halves.
    fill("map", 32'h0040_1000, 1'b0, mk_lo(20'h0ABCD, 3'd2, 1'b1),
         mk_lo(20'h12345, 3'd3, 1'b1));
    hit("refetch", 32'h0040_1000, 20'h12345, 1'b0, 1'b0);
    hit("even_nc", 32'h0040_0000, 20'h0ABCD, 1'b1, 1'b0);

    // Lookup miss in the main TLB -> refill fault, held while stalled, cleared by redirect.
    @(negedge clk);
    inst_vaddr = 32'h0080_0000;
    step("f_miss", mk(1'b1, 1'b0, 1'b0, 1'b0, 20'h0, 1'b0, 8'h0, 19'h0), M_EXC | M_REQ);
    @(negedge clk);
    lk_ack   = 1'b1;
    lk_found = 1'b0;
    step("f_req", mk(1'b1, 1'b0, 1'b0, 1'b0, 20'h0, 1'b1, 8'd5, 19'h00400),
         M_EXC | M_REQ | M_LK);
    @(negedge clk);
    lk_ack = 1'b0;
    stallF = 1'b1;
    step("f_refill", mk(1'b0, 1'b1, 1'b0, 1'b0, 20'h0, 1'b0, 8'h0, 19'h0), M_EXC | M_REQ);
    @(negedge clk);
    step("f_hold", mk(1'b0, 1'b1, 1'b0, 1'b0, 20'h0, 1'b0, 8'h0, 19'h0), M_EXC);
    @(negedge clk);
    inst_vaddr = 32'hBFC0_0380;
    stallF     = 1'b0;
    step("f_redirect", mk(1'b0, 1'b0, 1'b0, 1'b1, 20'h1FC00, 1'b0, 8'h0, 19'h0),
         M_EXC | M_NC | M_PFN);

    // Same page again: new miss (no refill), filled with V=0 on the even half.
    fill("v0", 32'h0080_0000, 1'b0, mk_lo(20'h00777, 3'd3, 1'b0),
         mk_lo(20'h00888, 3'd3, 1'b1));
    hit("v0_odd", 32'h0080_1000, 20'h00888, 1'b0, 1'b0);
    hit("v0_even", 32'h0080_0000, 20'h00777, 1'b0, 1'b1);

    // tlb_flush while in REQ: first ack dropped, request reissued, second ack fills.
    @(negedge clk);
    inst_vaddr = 32'h0100_0000;
    step("fl_miss", mk(1'b1, 1'b0, 1'b0, 1'b0, 20'h0, 1'b0, 8'h0, 19'h0), M_EXC | M_REQ);
    @(negedge clk);
    tlb_flush = 1'b1;
    step("fl_req", mk(1'b1, 1'b0, 1'b0, 1'b0, 20'h0, 1'b1, 8'd5, 19'h00800),
         M_EXC | M_REQ | M_LK);
    @(negedge clk);
    tlb_flush = 1'b0;
    lk_ack    = 1'b1;
    lk_found  = 1'b1;
    lk_g      = 1'b1;
    lk_lo0    = mk_lo(20'h11111, 3'd3, 1'b1);
    step("fl_drop_ack", mk(1'b1, 1'b0, 1'b0, 1'b0, 20'h0, 1'b1, 8'h0, 19'h0),
         M_EXC | M_REQ);
    @(negedge clk);
    lk_ack = 1'b0;
    step("fl_gap", mk(1'b1, 1'b0, 1'b0, 1'b0, 20'h0, 1'b0, 8'h0, 19'h0), M_EXC | M_REQ);
    @(negedge clk);
    lk_ack = 1'b1;
    lk_lo0 = mk_lo(20'h22222, 3'd3, 1'b1);
    step("fl_reissue", mk(1'b1, 1'b0, 1'b0, 1'b0, 20'h0, 1'b1, 8'd5, 19'h00800),
         M_EXC | M_REQ | M_LK);
    @(negedge clk);
    lk_ack   = 1'b0;
    lk_found = 1'b0;
    step("fl_fill", mk(1'b0, 1'b0, 1'b0, 1'b0, 20'h22222, 1'b0, 8'h0, 19'h0),
         M_EXC | M_NC | M_PFN | M_REQ);
    fill("fl_cleared", 32'h0040_1000, 1'b0, mk_lo(20'h0ABCD, 3'd2, 1'b1),
         mk_lo(20'h12345, 3'd3, 1'b1));

    // ASID 5 -> 6: non-global entry misses and is refetched under ASID 6.
    @(negedge clk);
    asid = 8'd6;
    step("as_miss", mk(1'b1, 1'b0, 1'b0, 1'b0, 20'h0, 1'b0, 8'h0, 19'h0), M_EXC | M_REQ);
    @(negedge clk);
    lk_ack   = 1'b1;
    lk_found = 1'b1;
    lk_g     = 1'b0;
    lk_lo0   = mk_lo(20'h0ABCD, 3'd2, 1'b1);
    lk_lo1   = mk_lo(20'h33333, 3'd3, 1'b1);
    step("as_req", mk(1'b1, 1'b0, 1'b0, 1'b0, 20'h0, 1'b1, 8'd6, 19'h00200),
         M_EXC | M_REQ | M_LK);
    @(negedge clk);
    lk_ack   = 1'b0;
    lk_found = 1'b0;
    step("as_fill", mk(1'b0, 1'b0, 1'b0, 1'b0, 20'h33333, 1'b0, 8'h0, 19'h0),
         M_EXC | M_PFN);
    // Global entry re-filled, then still hits when the ASID moves on.
    fill("as_g", 32'h0100_0000, 1'b1, mk_lo(20'h22222, 3'd3, 1'b1), 32'h0);
    @(negedge clk);
    asid = 8'd7;
    step("as_g_hit", mk(1'b0, 1'b0, 1'b0, 1'b0, 20'h22222, 1'b0, 8'h0, 19'h0),
         M_EXC | M_PFN);

    // Reset in the middle of REQ abandons the request; a late ack is ignored.
    @(negedge clk);
    inst_vaddr = 32'h0200_0000;
    step("mr_miss", mk(1'b1, 1'b0, 1'b0, 1'b0, 20'h0, 1'b0, 8'h0, 19'h0), M_EXC | M_REQ);
    @(negedge clk);
    step("mr_req", mk(1'b1, 1'b0, 1'b0, 1'b0, 20'h0, 1'b1, 8'd7, 19'h01000),
         M_EXC | M_REQ | M_LK);
    rst = 1'b0;
    step("mr_async_rst", mk(1'b0, 1'b0, 1'b0, 1'b0, 20'h0, 1'b0, 8'h0, 19'h0),
         M_EXC | M_REQ | M_LK);
    @(negedge clk);
    rst      = 1'b1;
    inst_en  = 1'b0;
    lk_ack   = 1'b1;
    lk_found = 1'b1;
    lk_g     = 1'b0;
    lk_lo0   = mk_lo(20'h0DEAD, 3'd3, 1'b1);
    step("mr_late_ack", mk(1'b0, 1'b0, 1'b0, 1'b0, 20'h0, 1'b0, 8'h0, 19'h0), M_REQ);

    // Round-robin: NE+1 distinct pages evict entry 0 (the first page).
    for (int k = 0; k <= NE; k++) begin
      fill($sformatf("rr%0d", k), 32'h0200_0000 + 32'(k) * 32'h2000, 1'b0,
           mk_lo(20'h40000 + 20'(k), 3'd3, 1'b1), mk_lo(20'h50000, 3'd3, 1'b1));
    end
    hit("rr_keep", 32'h0200_2000, 20'h40001, 1'b0, 1'b0);
    @(negedge clk);
    inst_vaddr = 32'h0200_0000;
    step("rr_evicted", mk(1'b1, 1'b0, 1'b0, 1'b0, 20'h0, 1'b0, 8'h0, 19'h0), M_EXC);
    @(negedge clk);
    inst_en = 1'b0;

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
